// File: rtl/dram_cmd_scheduler_pkg.sv
// dram_cmd_scheduler_pkg: shared types, timing defaults and counter helpers for the DDR4 command scheduler
package dram_cmd_scheduler_pkg;
  localparam int NUM_BG = 4;
  localparam int BANKS_PER_BG = 4;
  localparam int NUM_BANKS = NUM_BG * BANKS_PER_BG;
  localparam int CNT_W = 8;
  localparam int DEF_CLK_RATIO = 2;
  localparam int DEF_T_RCD = 24;
  localparam int DEF_T_RP = 24;
  localparam int DEF_T_RAS = 52;
  localparam int DEF_T_CCD_L = 8;
  localparam int DEF_T_CCD_S = 4;
  localparam int DEF_T_RRD = 4;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR} dram_cmd_t;
  typedef enum logic [2:0] {ST_IDLE, ST_DECIDE, ST_PRE, ST_ACT, ST_COL} sched_state_t;
  typedef struct packed {
    logic [31:0] time_stamp;
    logic [1:0]  op;
    logic [32:0] addr;
  } parser_out_struct_t;
  typedef struct packed {
    logic [14:0] row;
    logic [7:0]  col_hi;
    logic [1:0]  bank;
    logic [1:0]  bg;
    logic [2:0]  col_lo;
    logic [2:0]  offset;
  } dram_addr_t;
  typedef struct packed {
    logic             open;
    logic [14:0]      row;
    logic [CNT_W-1:0] rcd;
    logic [CNT_W-1:0] rp;
    logic [CNT_W-1:0] ras;
  } bank_state_t;
  function automatic logic [CNT_W-1:0] load_val(input int t);
    return t > 0 ? CNT_W'(t - 1) : '0;
  endfunction
  function automatic logic [CNT_W-1:0] tick_dec(input logic [CNT_W-1:0] c, input logic tick);
    return (tick && c != '0) ? c - CNT_W'(1) : c;
  endfunction
endpackage

// File: rtl/dram_cmd_scheduler_bank_timer.sv
// bank_timer: open-row tracking and tRCD/tRP/tRAS down-counters for one DRAM bank
module bank_timer import dram_cmd_scheduler_pkg::*; #(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        act,
  input  logic        pre,
  input  logic [14:0] act_row,
  output logic        is_open,
  output logic [14:0] open_row,
  output logic        can_act,
  output logic        can_pre,
  output logic        can_col
);
  bank_state_t s;
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else begin
      s.open <= act ? 1'b1 : pre ? 1'b0 : s.open;
      s.row <= act ? act_row : s.row;
      s.rcd <= act ? load_val(T_RCD) : tick_dec(s.rcd, tick);
      s.ras <= act ? load_val(T_RAS) : tick_dec(s.ras, tick);
      s.rp <= pre ? load_val(T_RP) : tick_dec(s.rp, tick);
    end
  assign is_open = s.open;
  assign open_row = s.row;
  assign can_act = s.rp == '0;
  assign can_pre = s.ras == '0;
  assign can_col = s.rcd == '0;
endmodule

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: in-order open-page DDR4 command issue for the queue head with per-bank and global timing
module dram_cmd_scheduler import dram_cmd_scheduler_pkg::*; #(
  parameter int CLK_RATIO = DEF_CLK_RATIO,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_CCD_L = DEF_T_CCD_L,
  parameter int T_CCD_S = DEF_T_CCD_S,
  parameter int T_RRD = DEF_T_RRD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               head_valid,
  input  parser_out_struct_t head,
  output logic               pop,
  output logic               cmd_valid,
  output dram_cmd_t          cmd,
  output logic [1:0]         cmd_bg,
  output logic [1:0]         cmd_bank,
  output logic [14:0]        cmd_addr,
  output logic               busy
);
  localparam int PH_W = CLK_RATIO > 1 ? $clog2(CLK_RATIO) : 1;
  sched_state_t st, st_n;
  parser_out_struct_t req;
  dram_addr_t a;
  logic [PH_W-1:0] phase;
  logic tick, issue, hit, col_ok, unused_ok;
  logic [3:0] idx;
  logic [NUM_BANKS-1:0] b_open, b_can_act, b_can_pre, b_can_col, b_act, b_pre;
  logic [14:0] b_row [NUM_BANKS];
  logic [CNT_W-1:0] rrd_cnt, ccd_cnt;
  logic [1:0] ccd_bg;
  assign a = dram_addr_t'(req.addr);
  assign idx = {a.bg, a.bank};
  assign tick = phase == '0;
  assign hit = b_open[idx] && b_row[idx] == a.row;
  assign col_ok = b_can_col[idx] && (ccd_cnt == '0 || (ccd_bg != a.bg && ccd_cnt <= CNT_W'(T_CCD_L - T_CCD_S)));
  assign issue = tick && !rst && (st == ST_PRE ? b_can_pre[idx] : st == ST_ACT ? b_can_act[idx] && rrd_cnt == '0 : st == ST_COL && col_ok);
  assign unused_ok = ^{req.time_stamp, a.offset};
  always_comb begin
    st_n = st;
    case (st)
      ST_IDLE: st_n = head_valid ? ST_DECIDE : ST_IDLE;
      ST_DECIDE: st_n = !b_open[idx] ? ST_ACT : hit ? ST_COL : ST_PRE;
      ST_PRE: st_n = issue ? ST_ACT : ST_PRE;
      ST_ACT: st_n = issue ? ST_COL : ST_ACT;
      ST_COL: st_n = issue ? ST_IDLE : ST_COL;
      default: st_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= ST_IDLE;
      req <= '0;
      phase <= '0;
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      ccd_bg <= '0;
    end else begin
      st <= st_n;
      if (st == ST_IDLE && head_valid) req <= head;
      phase <= phase == PH_W'(CLK_RATIO - 1) ? '0 : phase + PH_W'(1);
      rrd_cnt <= b_act != '0 ? load_val(T_RRD) : tick_dec(rrd_cnt, tick);
      ccd_cnt <= pop ? load_val(T_CCD_L) : tick_dec(ccd_cnt, tick);
      if (pop) ccd_bg <= a.bg;
    end
  assign cmd_valid = issue;
  assign pop = issue && st == ST_COL;
  assign cmd = !issue ? CMD_NOP : st == ST_PRE ? CMD_PRE : st == ST_ACT ? CMD_ACT : req.op == 2'd1 ? CMD_WR : CMD_RD;
  assign cmd_bg = issue ? a.bg : '0;
  assign cmd_bank = issue ? a.bank : '0;
  assign cmd_addr = !issue ? '0 : st == ST_ACT ? a.row : st == ST_COL ? {4'b0, a.col_hi, a.col_lo} : '0;
  assign busy = st != ST_IDLE;
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign b_act[g] = issue && st == ST_ACT && idx == 4'(g);
    assign b_pre[g] = issue && st == ST_PRE && idx == 4'(g);
    bank_timer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) u_bank (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .act(b_act[g]),
      .pre(b_pre[g]),
      .act_row(a.row),
      .is_open(b_open[g]),
      .open_row(b_row[g]),
      .can_act(b_can_act[g]),
      .can_pre(b_can_pre[g]),
      .can_col(b_can_col[g])
    );
  end
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler: directed requests checked against a timestamp model of DDR4 timing rules
module tb_dram_cmd_scheduler;
  import dram_cmd_scheduler_pkg::*;
  localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CCD_L = 8, T_CCD_S = 4, T_RRD = 4;
  typedef struct {int cyc; dram_cmd_t c; int bg; int bank; int addr;} rec_t;
  logic clk = 0, rst = 1, head_valid = 0, pop, cmd_valid, busy;
  parser_out_struct_t head = '0;
  dram_cmd_t cmd;
  logic [1:0] cmd_bg, cmd_bank;
  logic [14:0] cmd_addr;
  int n_chk = 0, n_fail = 0, cyc = 0, prev, prev_act;
  bit rst_q = 0, pop_seen = 0;
  rec_t lg[$], exp_q[$];
  bit m_open[16];
  int m_row[16], m_act_d[16], m_pre_d[16];
  int m_last_act, m_last_col, m_last_bg, m_acc, m_done;
  always #5 clk = ~clk;
  dram_cmd_scheduler #(
    .CLK_RATIO(2), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_CCD_L(T_CCD_L), .T_CCD_S(T_CCD_S), .T_RRD(T_RRD)
  ) dut (
    .clk(clk), .rst(rst), .head_valid(head_valid), .head(head), .pop(pop),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr), .busy(busy)
  );
  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int pk(input int p, input int v, input int c, input int bg, input int bk, input int ad);
    return (p << 23) | (v << 22) | (c << 19) | (bg << 17) | (bk << 15) | ad;
  endfunction
  function automatic rec_t mk(input int t, input dram_cmd_t c, input int bg, input int bk, input int ad);
    rec_t r;
    r.cyc = t;
    r.c = c;
    r.bg = bg;
    r.bank = bk;
    r.addr = ad;
    return r;
  endfunction
  function automatic int ce(input int x);
    return x + (x & 1);
  endfunction
  function automatic int mx(input int x, input int y);
    return x > y ? x : y;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 0;
      m_row[i] = 0;
      m_act_d[i] = -1000;
      m_pre_d[i] = -1000;
    end
    m_last_act = -1000;
    m_last_col = -1000;
    m_last_bg = -1;
    m_acc = -1;
    m_done = -1;
    exp_q.delete();
  endtask
  // Request accepted in cycle c: derive the full command plan from timestamps in DRAM clocks (cycle/2).
  task automatic plan(input int c, input logic [1:0] op, input logic [32:0] ad);
    int b, bg, bk, r, col, t;
    bg = int'(ad[7:6]);
    bk = int'(ad[9:8]);
    b = bg * 4 + bk;
    r = int'(ad[32:18]);
    col = int'({ad[17:10], ad[5:3]});
    t = ce(c + 2);
    if (m_open[b] && m_row[b] != r) begin
      t = mx(t, 2 * (m_act_d[b] + T_RAS));
      exp_q.push_back(mk(t, CMD_PRE, bg, bk, 0));
      m_pre_d[b] = t / 2;
      m_open[b] = 0;
      t += 2;
    end
    if (!m_open[b]) begin
      t = mx(t, mx(2 * (m_pre_d[b] + T_RP), 2 * (m_last_act + T_RRD)));
      exp_q.push_back(mk(t, CMD_ACT, bg, bk, r));
      m_act_d[b] = t / 2;
      m_last_act = t / 2;
      m_open[b] = 1;
      m_row[b] = r;
      t += 2;
    end
    t = mx(t, mx(2 * (m_act_d[b] + T_RCD), 2 * (m_last_col + (m_last_bg == bg ? T_CCD_L : T_CCD_S))));
    exp_q.push_back(mk(t, op == 2'd1 ? CMD_WR : CMD_RD, bg, bk, col));
    m_last_col = t / 2;
    m_last_bg = bg;
    m_acc = c;
    m_done = t;
  endtask
  always @(negedge clk) begin
    rec_t e;
    int ev, av;
    bit eb;
    av = pk(int'(pop), int'(cmd_valid), int'(cmd), int'(cmd_bg), int'(cmd_bank), int'(cmd_addr));
    if (cmd_valid) lg.push_back(mk(cyc, cmd, int'(cmd_bg), int'(cmd_bank), int'(cmd_addr)));
    if (pop) pop_seen = 1;
    if (rst) begin
      chk(av == 0 && cmd == CMD_NOP, "reset_quiet", av, 0);
      if (rst_q) chk(!busy, "reset_busy", int'(busy), 0);
      m_reset();
      cyc = 0;
    end else begin
      if (cyc > m_done && head_valid) plan(cyc, head.op, head.addr);
      ev = 0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        ev = pk(int'(e.c == CMD_RD || e.c == CMD_WR), 1, int'(e.c), e.bg, e.bank, e.addr);
      end
      chk(av == ev, "cmd_bundle", av, ev);
      eb = cyc > m_acc && cyc <= m_done;
      chk(busy == eb, "busy", int'(busy), int'(eb));
      cyc++;
    end
    rst_q = rst;
  end
  function automatic rec_t at(input int i);
    rec_t r;
    r = mk(-1, CMD_NOP, -1, -1, -1);
    if (i < lg.size()) r = lg[i];
    return r;
  endfunction
  task automatic exp_cmd(input string nm, input int i, input dram_cmd_t c, input int bg, input int bk, input int ad);
    rec_t r;
    r = at(i);
    chk(r.c == c && r.bg == bg && r.bank == bk && r.addr == ad, nm,
        pk(0, 0, int'(r.c), r.bg, r.bank, r.addr), pk(0, 0, int'(c), bg, bk, ad));
  endtask
  task automatic gap(input string nm, input int from, input int i, input int g);
    chk(at(i).cyc - from == g, nm, at(i).cyc - from, g);
  endtask
  task automatic n_cmds(input string nm, input int n);
    chk(lg.size() == n, nm, lg.size(), n);
  endtask
  task automatic wait_pop(input string nm);
    for (int n = 0; n < 1000 && !pop_seen; n++) @(posedge clk);
    chk(pop_seen, nm, int'(pop_seen), 1);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [32:0] ad, input string nm);
    head.time_stamp = cyc;
    head.op = op;
    head.addr = ad;
    head_valid = 1;
    lg.delete();
    pop_seen = 0;
    wait_pop(nm);
  endtask
  task automatic idle(input int n);
    head_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(4);
    send(2'd0, 33'h40000, "pop_rd_closed");
    n_cmds("rd_closed_count", 2);
    exp_cmd("rd_closed_act", 0, CMD_ACT, 0, 0, 1);
    exp_cmd("rd_closed_rd", 1, CMD_RD, 0, 0, 0);
    gap("rd_closed_rcd", at(0).cyc, 1, 48);
    prev_act = at(0).cyc;
    send(2'd0, 33'h80000, "pop_conflict");
    n_cmds("conflict_count", 3);
    exp_cmd("conflict_pre", 0, CMD_PRE, 0, 0, 0);
    gap("conflict_ras", prev_act, 0, 104);
    exp_cmd("conflict_act", 1, CMD_ACT, 0, 0, 2);
    gap("conflict_rp", at(0).cyc, 1, 48);
    exp_cmd("conflict_rd", 2, CMD_RD, 0, 0, 0);
    gap("conflict_rcd", at(1).cyc, 2, 48);
    prev = at(2).cyc;
    send(2'd0, 33'h80008, "pop_hit_same_bg");
    n_cmds("hit_same_bg_count", 1);
    exp_cmd("hit_same_bg_rd", 0, CMD_RD, 0, 0, 1);
    gap("ccd_l", prev, 0, 16);
    send(2'd0, 33'h80040, "pop_bg1_open");
    exp_cmd("bg1_act", 0, CMD_ACT, 1, 0, 2);
    exp_cmd("bg1_rd", 1, CMD_RD, 1, 0, 0);
    prev = at(1).cyc;
    send(2'd0, 33'h80000, "pop_hit_other_bg");
    exp_cmd("hit_other_bg_rd", 0, CMD_RD, 0, 0, 0);
    gap("ccd_s", prev, 0, 8);
    prev = at(0).cyc;
    send(2'd0, 33'h80010, "pop_hit_col2");
    exp_cmd("hit_col2_rd", 0, CMD_RD, 0, 0, 2);
    gap("ccd_l_again", prev, 0, 16);
    send(2'd1, 33'h240, "pop_write");
    exp_cmd("write_act", 0, CMD_ACT, 1, 2, 0);
    exp_cmd("write_wr", 1, CMD_WR, 1, 2, 0);
    send(2'd2, 33'h248, "pop_ifetch");
    n_cmds("ifetch_count", 1);
    exp_cmd("ifetch_rd", 0, CMD_RD, 1, 2, 1);
    idle(6);
    head.addr = 33'h40100;
    head.op = 2'd0;
    head_valid = 1;
    lg.delete();
    pop_seen = 0;
    for (int n = 0; n < 200 && lg.size() == 0; n++) @(posedge clk);
    exp_cmd("midrst_act", 0, CMD_ACT, 0, 1, 1);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk(!pop_seen, "midrst_no_pop", int'(pop_seen), 0);
    lg.delete();
    wait_pop("pop_after_reset");
    exp_cmd("after_reset_act", 0, CMD_ACT, 0, 1, 1);
    chk(at(0).cyc == 2, "after_reset_act_cycle", at(0).cyc, 2);
    exp_cmd("after_reset_rd", 1, CMD_RD, 0, 1, 0);
    chk(at(1).cyc == 50, "after_reset_rd_cycle", at(1).cyc, 50);
    send(2'd0, 33'h80000, "pop_closed_by_reset");
    exp_cmd("closed_by_reset_act", 0, CMD_ACT, 0, 0, 2);
    n_cmds("closed_by_reset_count", 2);
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
